// File: rtl/window_event_accumulator_if.sv
// Event coordinate stream from the decoder/FIFO into the window accumulator.
// The producer drives valid and the coordinates; the accumulator drives ready.
interface window_event_accumulator_if #(
   parameter int COORD_BITS = 7
);
   logic                  ev_valid;
   logic                  ev_ready;
   logic [COORD_BITS-1:0] ev_x;
   logic [COORD_BITS-1:0] ev_y;

   modport master (output ev_valid, output ev_x, output ev_y, input  ev_ready);
   modport slave  (input  ev_valid, input  ev_x, input  ev_y, output ev_ready);
endinterface

// File: rtl/window_event_accumulator.sv
// Accumulates centred event sums and counts into an early and a late half-window bank.
// Both banks are published as one registered snapshot, with a one-cycle trigger, at each window end.
module window_event_accumulator #(
   parameter int COORD_BITS     = 7,
   parameter int ACC_SUM_BITS   = 18,
   parameter int ACC_COUNT_BITS = 12,
   parameter int HALF_PERIOD    = 100000
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_enable,
   window_event_accumulator_if.slave       ev_if,
   output logic signed [ACC_SUM_BITS-1:0]  o_early_sum_x,
   output logic signed [ACC_SUM_BITS-1:0]  o_early_sum_y,
   output logic [ACC_COUNT_BITS-1:0]       o_early_count,
   output logic signed [ACC_SUM_BITS-1:0]  o_late_sum_x,
   output logic signed [ACC_SUM_BITS-1:0]  o_late_sum_y,
   output logic [ACC_COUNT_BITS-1:0]       o_late_count,
   output logic                            o_sat_flag,
   output logic                            o_trigger
);
   localparam int                    CNT_W  = $clog2(HALF_PERIOD);
   localparam logic [CNT_W-1:0]      LAST   = CNT_W'(HALF_PERIOD - 1);
   localparam logic [COORD_BITS:0]   CENTRE = (COORD_BITS+1)'(2 ** (COORD_BITS - 1));

   typedef enum logic [1:0] {IDLE, EARLY, LATE, PUBLISH} state_t;

   state_t                          r_state, w_state_nxt;
   logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
   logic                            w_clear, w_publish, w_accept, w_last;

   logic signed [ACC_SUM_BITS-1:0]  r_e_sx, r_e_sy, r_l_sx, r_l_sy;
   logic [ACC_COUNT_BITS-1:0]       r_e_cnt, r_l_cnt;
   logic                            r_sat;

   logic signed [ACC_SUM_BITS-1:0]  r_early_sum_x, r_early_sum_y, r_late_sum_x, r_late_sum_y;
   logic [ACC_COUNT_BITS-1:0]       r_early_count, r_late_count;
   logic                            r_sat_flag, r_trigger;

   logic signed [COORD_BITS:0]      w_xc, w_yc;
   logic signed [ACC_SUM_BITS-1:0]  w_sel_sx, w_sel_sy, w_upd_sx, w_upd_sy;
   logic [ACC_COUNT_BITS-1:0]       w_sel_cnt, w_upd_cnt;
   logic [ACC_SUM_BITS:0]           w_rx, w_ry;
   logic                            w_sat_set;

   // Returns {clip, value}: value is the sum clamped to the signed range of ACC_SUM_BITS.
   function automatic logic [ACC_SUM_BITS:0] f_sat_add(
      input logic signed [ACC_SUM_BITS-1:0] a,
      input logic signed [COORD_BITS:0]     d
   );
      logic [ACC_SUM_BITS:0] s;
      s = {a[ACC_SUM_BITS-1], a} + {{(ACC_SUM_BITS-COORD_BITS){d[COORD_BITS]}}, d};
      if (s[ACC_SUM_BITS] != s[ACC_SUM_BITS-1])
         f_sat_add = {1'b1, s[ACC_SUM_BITS], {(ACC_SUM_BITS-1){~s[ACC_SUM_BITS]}}};
      else
         f_sat_add = {1'b0, s[ACC_SUM_BITS-1:0]};
   endfunction

   assign ev_if.ev_ready = (r_state == EARLY) || (r_state == LATE);
   assign w_accept       = ev_if.ev_valid && ev_if.ev_ready;
   assign w_last         = (r_cnt == LAST);
   assign w_xc           = $signed({1'b0, ev_if.ev_x} - CENTRE);
   assign w_yc           = $signed({1'b0, ev_if.ev_y} - CENTRE);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clear     = 1'b0;
      w_publish   = 1'b0;
      case (r_state)
         IDLE: begin
            w_clear = 1'b1;
            if (i_enable) begin
               w_state_nxt = EARLY;
               w_cnt_nxt   = '0;
            end
         end
         EARLY, LATE: begin
            if (!i_enable) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_clear     = 1'b1;
            end else if (w_last) begin
               w_state_nxt = (r_state == EARLY) ? LATE : PUBLISH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         PUBLISH: begin
            w_clear   = 1'b1;
            w_cnt_nxt = '0;
            if (!i_enable) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = EARLY;
               w_publish   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
         end
      endcase
   end

   // One shared update path; the state picks which bank it reads and writes.
   always_comb begin
      w_sel_sx  = (r_state == LATE) ? r_l_sx  : r_e_sx;
      w_sel_sy  = (r_state == LATE) ? r_l_sy  : r_e_sy;
      w_sel_cnt = (r_state == LATE) ? r_l_cnt : r_e_cnt;
      w_upd_sx  = w_sel_sx;
      w_upd_sy  = w_sel_sy;
      w_upd_cnt = w_sel_cnt;
      w_rx      = '0;
      w_ry      = '0;
      w_sat_set = 1'b0;
      if (w_accept) begin
         if (&w_sel_cnt) begin
            w_sat_set = 1'b1;
         end else begin
            w_rx      = f_sat_add(w_sel_sx, w_xc);
            w_ry      = f_sat_add(w_sel_sy, w_yc);
            w_upd_sx  = w_rx[ACC_SUM_BITS-1:0];
            w_upd_sy  = w_ry[ACC_SUM_BITS-1:0];
            w_upd_cnt = w_sel_cnt + ACC_COUNT_BITS'(1);
            w_sat_set = w_rx[ACC_SUM_BITS] | w_ry[ACC_SUM_BITS];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_e_sx        <= '0;
         r_e_sy        <= '0;
         r_e_cnt       <= '0;
         r_l_sx        <= '0;
         r_l_sy        <= '0;
         r_l_cnt       <= '0;
         r_sat         <= 1'b0;
         r_early_sum_x <= '0;
         r_early_sum_y <= '0;
         r_early_count <= '0;
         r_late_sum_x  <= '0;
         r_late_sum_y  <= '0;
         r_late_count  <= '0;
         r_sat_flag    <= 1'b0;
         r_trigger     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_trigger <= w_publish;
         if (w_publish) begin
            r_early_sum_x <= r_e_sx;
            r_early_sum_y <= r_e_sy;
            r_early_count <= r_e_cnt;
            r_late_sum_x  <= r_l_sx;
            r_late_sum_y  <= r_l_sy;
            r_late_count  <= r_l_cnt;
            r_sat_flag    <= r_sat;
         end
         if (w_clear) begin
            r_e_sx  <= '0;
            r_e_sy  <= '0;
            r_e_cnt <= '0;
            r_l_sx  <= '0;
            r_l_sy  <= '0;
            r_l_cnt <= '0;
            r_sat   <= 1'b0;
         end else begin
            if (w_accept && (r_state == EARLY)) begin
               r_e_sx  <= w_upd_sx;
               r_e_sy  <= w_upd_sy;
               r_e_cnt <= w_upd_cnt;
            end
            if (w_accept && (r_state == LATE)) begin
               r_l_sx  <= w_upd_sx;
               r_l_sy  <= w_upd_sy;
               r_l_cnt <= w_upd_cnt;
            end
            r_sat <= r_sat | w_sat_set;
         end
      end
   end

   assign o_early_sum_x = r_early_sum_x;
   assign o_early_sum_y = r_early_sum_y;
   assign o_early_count = r_early_count;
   assign o_late_sum_x  = r_late_sum_x;
   assign o_late_sum_y  = r_late_sum_y;
   assign o_late_count  = r_late_count;
   assign o_sat_flag    = r_sat_flag;
   assign o_trigger     = r_trigger;
endmodule

// File: tb/tb_window_event_accumulator.sv
// Directed bench: u0 covers timing, boundaries and reset; u1 count saturation; u2 sum clamp and enable drop.
module tb_window_event_accumulator;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, en0, en1, en2;
   window_event_accumulator_if #(.COORD_BITS(7)) if0 ();
   window_event_accumulator_if #(.COORD_BITS(7)) if1 ();
   window_event_accumulator_if #(.COORD_BITS(7)) if2 ();

   logic signed [17:0] a_esx, a_esy, a_lsx, a_lsy;
   logic [11:0]        a_ec, a_lc;
   logic               a_sat, a_trg;
   logic signed [17:0] b_esx, b_esy, b_lsx, b_lsy;
   logic [3:0]         b_ec, b_lc;
   logic               b_sat, b_trg;
   logic signed [7:0]  c_esx, c_esy, c_lsx, c_lsy;
   logic [11:0]        c_ec, c_lc;
   logic               c_sat, c_trg;

   window_event_accumulator #(.HALF_PERIOD(8)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en0), .ev_if(if0),
      .o_early_sum_x(a_esx), .o_early_sum_y(a_esy), .o_early_count(a_ec),
      .o_late_sum_x(a_lsx), .o_late_sum_y(a_lsy), .o_late_count(a_lc),
      .o_sat_flag(a_sat), .o_trigger(a_trg));

   window_event_accumulator #(.HALF_PERIOD(24), .ACC_COUNT_BITS(4)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en1), .ev_if(if1),
      .o_early_sum_x(b_esx), .o_early_sum_y(b_esy), .o_early_count(b_ec),
      .o_late_sum_x(b_lsx), .o_late_sum_y(b_lsy), .o_late_count(b_lc),
      .o_sat_flag(b_sat), .o_trigger(b_trg));

   window_event_accumulator #(.HALF_PERIOD(8), .ACC_SUM_BITS(8)) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(en2), .ev_if(if2),
      .o_early_sum_x(c_esx), .o_early_sum_y(c_esy), .o_early_count(c_ec),
      .o_late_sum_x(c_lsx), .o_late_sum_y(c_lsy), .o_late_count(c_lc),
      .o_sat_flag(c_sat), .o_trigger(c_trg));

   int total = 0, bad = 0, cyc = 0;
   int ntrg [3] = '{0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (a_trg) ntrg[0]++;
      if (b_trg) ntrg[1]++;
      if (c_trg) ntrg[2]++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   function automatic logic trg(input int d);
      case (d)
         0:       return a_trg;
         1:       return b_trg;
         default: return c_trg;
      endcase
   endfunction

   task automatic wait_trg(input int d, input string tag);
      int n;
      n = 0;
      while (!trg(d) && n < 120) begin
         @(negedge clk);
         n++;
      end
      chk(tag, int'(trg(d)), 1);
   endtask

   task automatic ev0(input int x, input int y);
      if0.ev_valid = 1'b1;
      if0.ev_x     = 7'(x);
      if0.ev_y     = 7'(y);
      @(negedge clk);
      if0.ev_valid = 1'b0;
   endtask

   task automatic ev2(input int x, input int y);
      if2.ev_valid = 1'b1;
      if2.ev_x     = 7'(x);
      if2.ev_y     = 7'(y);
      @(negedge clk);
      if2.ev_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: cyc=%0d expected run to finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int e, w, f, g, h, n;
      rst_n = 1'b0; en0 = 1'b1; en1 = 1'b0; en2 = 1'b0;
      if0.ev_valid = 1'b1; if0.ev_x = 7'd70; if0.ev_y = 7'd60;
      if1.ev_valid = 1'b0; if1.ev_x = '0;    if1.ev_y = '0;
      if2.ev_valid = 1'b0; if2.ev_x = '0;    if2.ev_y = '0;
      repeat (5) @(negedge clk);
      chk("rst_esx", a_esx, 0);
      chk("rst_esy", a_esy, 0);
      chk("rst_ec",  a_ec, 0);
      chk("rst_lsx", a_lsx, 0);
      chk("rst_lsy", a_lsy, 0);
      chk("rst_lc",  a_lc, 0);
      chk("rst_sat", a_sat, 0);
      chk("rst_rdy", if0.ev_ready, 0);
      chk("rst_ntrg", ntrg[0], 0);

      // Basic window; e is the first EARLY cycle, entered by the edge that samples enable.
      if0.ev_valid = 1'b0;
      rst_n = 1'b1;
      e = cyc + 1;
      wait_cyc(e);
      chk("rdy_early", if0.ev_ready, 1);
      ev0(70, 60); ev0(74, 60); ev0(66, 64);
      wait_cyc(e + 8);
      ev0(10, 100); ev0(20, 100);
      wait_trg(0, "trg_basic");
      chk("trg_lat", cyc - e + 1, 18);
      chk("b_esx", a_esx, 18);
      chk("b_esy", a_esy, -8);
      chk("b_ec",  a_ec, 3);
      chk("b_lsx", a_lsx, -98);
      chk("b_lsy", a_lsy, 72);
      chk("b_lc",  a_lc, 2);
      chk("b_sat", a_sat, 0);
      chk("b_ntrg", ntrg[0], 1);
      @(negedge clk);
      chk("trg_pulse", a_trg, 0);

      // Last EARLY cycle, first LATE cycle, then valid held across PUBLISH.
      w = e + 17;
      wait_cyc(w + 7);
      ev0(80, 64);
      ev0(40, 64);
      wait_cyc(w + 16);
      if0.ev_valid = 1'b1; if0.ev_x = 7'd100; if0.ev_y = 7'd64;
      chk("rdy_pub", if0.ev_ready, 0);
      @(negedge clk);
      chk("bd_trg", a_trg, 1);
      chk("bd_esx", a_esx, 16);
      chk("bd_ec",  a_ec, 1);
      chk("bd_lsx", a_lsx, -24);
      chk("bd_lc",  a_lc, 1);
      chk("rdy_after_pub", if0.ev_ready, 1);
      @(negedge clk);
      if0.ev_valid = 1'b0;
      w = w + 17;
      wait_trg(0, "trg_w2");
      chk("w2_period", cyc - w, 17);
      chk("w2_esx", a_esx, 36);
      chk("w2_ec",  a_ec, 1);
      chk("w2_lc",  a_lc, 0);

      // Reset mid-EARLY after two accepted events.
      ev0(100, 64); ev0(100, 64);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mr_esx", a_esx, 0);
      chk("mr_ec",  a_ec, 0);
      chk("mr_trg", a_trg, 0);
      chk("mr_rdy", if0.ev_ready, 0);
      rst_n = 1'b1;
      e = cyc + 1;
      wait_cyc(e);
      ev0(60, 64);
      wait_trg(0, "trg_mr");
      chk("mr_period", cyc - e, 17);
      chk("mr_esx2", a_esx, -4);
      chk("mr_ec2",  a_ec, 1);
      chk("mr_lc2",  a_lc, 0);
      en0 = 1'b0;

      // Count saturation: 4-bit counter, 20 events at x=127.
      en1 = 1'b1;
      f = cyc + 1;
      wait_cyc(f);
      if1.ev_valid = 1'b1; if1.ev_x = 7'd127; if1.ev_y = 7'd64;
      repeat (20) @(negedge clk);
      if1.ev_valid = 1'b0;
      wait_trg(1, "trg_cs");
      chk("cs_ec",  b_ec, 15);
      chk("cs_esx", b_esx, 945);
      chk("cs_esy", b_esy, 0);
      chk("cs_lc",  b_lc, 0);
      chk("cs_sat", b_sat, 1);
      en1 = 1'b0;

      // Sum clamp at 8 bits: 3 x 63 clips to 127.
      en2 = 1'b1;
      g = cyc + 1;
      wait_cyc(g);
      ev2(127, 64); ev2(127, 64); ev2(127, 64);
      wait_trg(2, "trg_ss");
      chk("ss_esx", c_esx, 127);
      chk("ss_ec",  c_ec, 3);
      chk("ss_sat", c_sat, 1);

      // Enable dropped mid-LATE: nothing published, snapshot holds.
      ev2(0, 64);
      wait_cyc(g + 27);
      en2 = 1'b0;
      n = ntrg[2];
      repeat (20) @(negedge clk);
      chk("ed_ntrg", ntrg[2], n);
      chk("ed_esx", c_esx, 127);
      chk("ed_ec",  c_ec, 3);
      chk("ed_sat", c_sat, 1);
      chk("ed_rdy", if2.ev_ready, 0);
      en2 = 1'b1;
      h = cyc + 1;
      wait_cyc(h);
      ev2(10, 64);
      wait_trg(2, "trg_re");
      chk("re_period", cyc - h, 17);
      chk("re_esx", c_esx, -54);
      chk("re_ec",  c_ec, 1);
      chk("re_lc",  c_lc, 0);
      chk("re_sat", c_sat, 0);
      en2 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/window_event_accumulator.md
Name: window_event_accumulator

Overview:
- Producer side of the motion-computation interface: builds the early/late half-window centroid sums that the motion stage differences.
- Accepts a valid/ready stream of DVS event coordinates and accumulates centred x/y sums and event counts into an early bank, then a late bank, over fixed half-periods.
- At each window end, publishes a registered snapshot of both banks with a one-cycle trigger, then clears and restarts.
- Sits between the event decoder/FIFO and the motion-computation stage.

Parameters:
- COORD_BITS, 7, width of unsigned event coordinates (128x128 sensor).
- ACC_SUM_BITS, 18, width of signed sum outputs.
- ACC_COUNT_BITS, 12, width of unsigned count outputs.
- HALF_PERIOD, 100000, cycles per half-window; must be >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  run windows when high; idle and clear when low.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accepted when ev_valid && ev_ready.
- ev_x  in  COORD_BITS  event x coordinate.
- ev_y  in  COORD_BITS  event y coordinate.
- early_sum_x  out  ACC_SUM_BITS signed  early-half centred x sum.
- early_sum_y  out  ACC_SUM_BITS signed  early-half centred y sum.
- early_count  out  ACC_COUNT_BITS  early-half event count.
- late_sum_x  out  ACC_SUM_BITS signed  late-half centred x sum.
- late_sum_y  out  ACC_SUM_BITS signed  late-half centred y sum.
- late_count  out  ACC_COUNT_BITS  late-half event count.
- sat_flag  out  1  an event was dropped or a sum clipped in the published window.
- trigger  out  1  one-cycle pulse; snapshot outputs updated this cycle.

Behaviour:
- Reset (rst_n low at edge): all outputs 0, ev_ready 0, banks cleared, state IDLE, phase counter 0. Reset has priority over everything, including mid-window.
- FSM states: IDLE, EARLY, LATE, PUBLISH.
  - IDLE: if enable is high, go to EARLY with counter 0. Banks are held clear.
  - EARLY: lasts HALF_PERIOD cycles, then LATE with counter 0.
  - LATE: lasts HALF_PERIOD cycles, then PUBLISH.
  - PUBLISH: lasts 1 cycle, then EARLY.
  - Window period: 2*HALF_PERIOD+1 cycles.
- enable low in any non-IDLE state: next state is IDLE and banks clear. No trigger, and snapshot outputs and sat_flag hold their last published values.
- ev_ready: 1 in EARLY and LATE; 0 in IDLE and PUBLISH. Combinational from state only, never from ev_valid.
- Accepted event:
  - Centre each coordinate: xc = ev_x - 2^(COORD_BITS-1), yc likewise, signed.
  - Accumulate into the bank selected by the state in the acceptance cycle; the bank updates at the next edge.
  - An event accepted on the last LATE cycle is included in the publish.
- Count saturation: a bank whose count equals 2^ACC_COUNT_BITS-1 drops further events entirely (sums unchanged) and sets the window's internal sat bit.
- Sum saturation: each sum clamps to [-2^(ACC_SUM_BITS-1), 2^(ACC_SUM_BITS-1)-1] and sets the sat bit on clip. Count still increments.
- PUBLISH edge: all snapshot outputs load from the banks, sat_flag loads the sat bit, trigger is 1 for the next cycle only, and banks and sat bit clear.
  - Snapshot outputs change only at this edge (or at reset).
- No back-pressure from downstream: trigger is fire-and-forget.
- Latency: from an event being accepted to it appearing on the outputs equals the remaining window time plus 1 cycle.

Test Plan:
- Reset: hold rst_n low 5 cycles while driving ev_valid=1 and enable=1 -> all outputs 0, ev_ready 0, no trigger.
- Basic window (HALF_PERIOD=8):
  - Stimulus: early events (70,60), (74,60), (66,64); late events (10,100), (20,100).
  - Expected: single trigger pulse 18 cycles after enable is first sampled high.
  - Snapshot: early_sum_x=18, early_sum_y=-8, early_count=3, late_sum_x=-98, late_sum_y=72, late_count=2, sat_flag=0.
- Boundaries:
  - Event held on the last EARLY cycle -> counted early; event on the first LATE cycle -> counted late.
  - ev_valid held through PUBLISH -> ev_ready=0, event accepted on the first EARLY cycle and appears in the next window.
- Saturation:
  - ACC_COUNT_BITS=4: 20 early events at x=127 -> early_count=15, early_sum_x=945, sat_flag=1.
  - ACC_SUM_BITS=8: 3 events at x=127 -> sum_x clamps to 127, count 3, sat_flag=1.
- Enable drop mid-LATE: no trigger, outputs keep the prior window's values. On re-enable, the next trigger carries only new-window events, with sat_flag cleared.
- Reset mid-EARLY after 2 events -> outputs 0 immediately. After rst_n release with enable high, the first window excludes the pre-reset events.
